uart_tx_serializer: RTL
=======================

# uart_tx_serializer

UART transmit serializer that drains the transmit byte FIFO and drives the serial `tx` line. Whenever the FIFO is non-empty and the serializer is idle, it pops one word and shifts it out as an asynchronous frame:

- one start bit;
- DATA_WIDTH data bits, LSB first;
- an optional parity bit;
- one or two stop bits.

Bit timing comes from an internal clock-divide counter, so no external baud tick is required.

## Interface

Parameters:
- `DATA_WIDTH`, default 8: bits per frame; must match the FIFO data width.
- `CLKS_PER_BIT`, default 868: clk cycles per serial bit (100 MHz / 115200). Legal range is 2 or more.
- `PARITY_EN`, default 0: 1 inserts a parity bit after the data bits.
- `PARITY_ODD`, default 0: 0 selects even parity, 1 selects odd. Ignored when `PARITY_EN`=0.
- `STOP_BITS`, default 1: number of stop bits, 1 or 2.

Ports:
- `clk` input, 1: system clock; all state changes on the rising edge.
- `reset` input, 1: asynchronous, active-low reset.
- `fifo_empty` input, 1: FIFO empty flag.
- `fifo_dout` input, DATA_WIDTH: FIFO head word; valid whenever `fifo_empty`=0 (show-ahead).
- `fifo_rd_en` output, 1: FIFO pop strobe; exactly one cycle per frame.
- `tx` output, 1: serial line; idles high.
- `busy` output, 1: high from the cycle after the pop until frame end.
- `tx_done` output, 1: one-cycle pulse in the last clk cycle of the final stop bit.

## Operation

- FSM states: IDLE → START → DATA → PARITY (only if `PARITY_EN`) → STOP → IDLE.
- **IDLE**
  - `fifo_rd_en` = (state==IDLE) && !`fifo_empty`. This is combinational from registered state and the input.
  - In that same cycle, `fifo_dout` is captured into the shift register, parity is computed and registered, and the state moves to START.
- **START:** `tx`=0 for CLKS_PER_BIT cycles.
- **DATA**
  - `tx` = shift_reg[0]; each bit is held CLKS_PER_BIT cycles.
  - The shift register shifts right at each bit boundary.
  - A bit index counter of $clog2(DATA_WIDTH) bits advances 0..DATA_WIDTH-1. After the last bit, go to PARITY or STOP.
- **PARITY**
  - `tx` = XOR of the captured data, inverted when `PARITY_ODD`=1.
  - Held CLKS_PER_BIT cycles.
- **STOP**
  - `tx`=1 for STOP_BITS×CLKS_PER_BIT cycles.
  - `tx_done` is high in the final cycle; the state then returns to IDLE.
- **Divide counter**
  - Width $clog2(CLKS_PER_BIT); counts 0..CLKS_PER_BIT-1 and wraps to 0 at each bit boundary.
  - Cleared on entry to START.
- **`tx` output:** registered, driven from state and shift register; no combinational glitching.
- **Empty FIFO:** no pop, `tx` stays 1, `busy` stays 0.
- **`fifo_empty` falling mid-frame:** ignored until the state returns to IDLE.
- **Boundary behaviour:**
  - There are no back-pressure or abort inputs; a frame always completes unless reset.
  - `fifo_rd_en` is never asserted outside IDLE, so a pop of an empty FIFO is impossible.

## Timing

- Reset values: state=IDLE, `tx`=1, `busy`=0, `fifo_rd_en`=0, `tx_done`=0, counters=0, shift register=0.
- Reset asserted mid-frame:
  - `tx` returns to 1 asynchronously and the frame is abandoned; the popped byte is lost.
  - After release, operation resumes from IDLE with the next FIFO word.
- Pop in cycle T puts the start bit on `tx` from cycle T+1. Latency from `fifo_empty` falling to `tx` falling is 1 cycle.
- Frame length F = (1 + DATA_WIDTH + PARITY_EN + STOP_BITS) × CLKS_PER_BIT cycles, covering T+1..T+F.
- `tx_done` fires at cycle T+F.
- `busy`=1 over cycles T+1..T+F.
- At T+F+1 the state is IDLE, so the earliest next pop is at T+F+1. The inter-frame gap on `tx` is therefore exactly 1 idle cycle of `tx`=1 when the FIFO stays non-empty.
- Data bit k occupies cycles T+1+(1+k)×CLKS_PER_BIT .. T+(2+k)×CLKS_PER_BIT.

## Test plan

All scenarios use `CLKS_PER_BIT`=4.

- **Reset with FIFO non-empty:** `reset` held 0 → `tx`=1, `busy`=0, `fifo_rd_en`=0, `tx_done`=0. No pop until `reset` is released.
- **Single 0xA5, 8N1, popped at T:**
  - Exactly one `fifo_rd_en` pulse, at T.
  - `tx` carries 0,1,0,1,0,0,1,0,1,1, each held 4 cycles, over T+1..T+40.
  - `tx_done`=1 only at T+40.
  - `busy` high T+1..T+40.
- **Back-to-back 0x00 then 0xFF with FIFO continuously non-empty:**
  - Pops at T and T+41.
  - `tx`=1 at T+41 only, then the second start bit begins at T+42.
  - The second frame's data bits all read 1.
- **Parity:**
  - `PARITY_EN`=1, `PARITY_ODD`=0, byte 0x07 → parity bit 1; frame length 44 cycles.
  - Same with `PARITY_ODD`=1 → parity bit 0.
  - Byte 0x00 with even parity → parity bit 0.
- **`STOP_BITS`=2, byte 0x3C:** `tx` high for 8 cycles after bit 7; `tx_done` at T+44; next pop no earlier than T+45.
- **Reset during data bit 3 of 0xA5:**
  - `tx` goes to 1 in the same cycle, asynchronously; `busy` drops to 0.
  - After release, the next FIFO word is popped and sent in full with a correct frame.

Source files
------------

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: pops one word from a show-ahead FIFO and sends it
// as start, DATA_WIDTH data bits (LSB first), optional parity and 1 or 2 stop bits.
module uart_tx_serializer #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 868,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    output logic                  fifo_rd_en,
    output logic                  tx,
    output logic                  busy,
    output logic                  tx_done
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_WIDTH - 1);
    localparam logic             STOP_LAST = (STOP_BITS == 2);
    localparam logic             ODD_SEL   = (PARITY_ODD != 0);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t                r_state;
    logic [CNT_W-1:0]      r_clk_cnt;
    logic [IDX_W-1:0]      r_bit_idx;
    logic                  r_stop_idx;
    logic [DATA_WIDTH-1:0] r_shift;
    logic                  r_parity;
    logic                  r_tx;

    state_t                w_state_next;
    logic [CNT_W-1:0]      w_clk_cnt_next;
    logic [IDX_W-1:0]      w_bit_idx_next;
    logic                  w_stop_idx_next;
    logic [DATA_WIDTH-1:0] w_shift_next;
    logic [DATA_WIDTH-1:0] w_shifted;
    logic                  w_parity_next;
    logic                  w_tx_next;
    logic                  w_pop;
    logic                  w_bit_end;
    logic                  w_done;

    // Gating with reset keeps the pop strobe quiet while reset is held.
    assign w_pop     = reset && (r_state == IDLE) && !fifo_empty;
    assign w_bit_end = (r_clk_cnt == CNT_LAST);
    assign w_shifted = r_shift >> 1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_clk_cnt  <= '0;
            r_bit_idx  <= '0;
            r_stop_idx <= 1'b0;
            r_shift    <= '0;
            r_parity   <= 1'b0;
            r_tx       <= 1'b1;
        end else begin
            r_state    <= w_state_next;
            r_clk_cnt  <= w_clk_cnt_next;
            r_bit_idx  <= w_bit_idx_next;
            r_stop_idx <= w_stop_idx_next;
            r_shift    <= w_shift_next;
            r_parity   <= w_parity_next;
            r_tx       <= w_tx_next;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_clk_cnt_next  = r_clk_cnt;
        w_bit_idx_next  = r_bit_idx;
        w_stop_idx_next = r_stop_idx;
        w_shift_next    = r_shift;
        w_parity_next   = r_parity;
        w_tx_next       = r_tx;
        w_done          = 1'b0;

        if (r_state != IDLE) begin
            w_clk_cnt_next = w_bit_end ? '0 : r_clk_cnt + 1'b1;
        end

        // r_tx is loaded with the level of the state being entered, so the
        // line changes exactly at the bit boundary without a decode glitch.
        case (r_state)
            IDLE: begin
                w_tx_next = 1'b1;
                if (w_pop) begin
                    w_shift_next    = fifo_dout;
                    w_parity_next   = (^fifo_dout) ^ ODD_SEL;
                    w_clk_cnt_next  = '0;
                    w_bit_idx_next  = '0;
                    w_stop_idx_next = 1'b0;
                    w_tx_next       = 1'b0;
                    w_state_next    = START;
                end
            end
            START: begin
                if (w_bit_end) begin
                    w_bit_idx_next = '0;
                    w_tx_next      = r_shift[0];
                    w_state_next   = DATA;
                end
            end
            DATA: begin
                if (w_bit_end) begin
                    if (r_bit_idx == IDX_LAST) begin
                        if (PARITY_EN != 0) begin
                            w_tx_next    = r_parity;
                            w_state_next = PARITY;
                        end else begin
                            w_stop_idx_next = 1'b0;
                            w_tx_next       = 1'b1;
                            w_state_next    = STOP;
                        end
                    end else begin
                        w_shift_next   = w_shifted;
                        w_tx_next      = w_shifted[0];
                        w_bit_idx_next = r_bit_idx + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (w_bit_end) begin
                    w_stop_idx_next = 1'b0;
                    w_tx_next       = 1'b1;
                    w_state_next    = STOP;
                end
            end
            STOP: begin
                w_tx_next = 1'b1;
                if (w_bit_end) begin
                    if (r_stop_idx == STOP_LAST) begin
                        w_done       = 1'b1;
                        w_state_next = IDLE;
                    end else begin
                        w_stop_idx_next = 1'b1;
                    end
                end
            end
            default: begin
                w_tx_next    = 1'b1;
                w_state_next = IDLE;
            end
        endcase
    end

    assign fifo_rd_en = w_pop;
    assign tx         = r_tx;
    assign busy       = (r_state != IDLE);
    assign tx_done    = w_done;

endmodule
